sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 16, gives the number of switch channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), gives the stable-time threshold in clk cycles; legal range is at least 1.
REQ-003 Parameter CNT_W, default 20, gives the per-channel counter width; it SHALL be able to hold DEBOUNCE_CYCLES-1.
REQ-004 clk, input, 1 bit: board clock; the only clock, all state updates on its rising edge.
REQ-005 rstn, input, 1 bit: synchronous, active-low reset.
REQ-006 sw_raw, input, WIDTH bits: asynchronous, bouncing switch pins.
REQ-007 sw_o, output, WIDTH bits: debounced switch levels, feeding the switch input of the I/O bus and display mux.
REQ-008 rise_o, output, WIDTH bits: one-cycle pulse per channel when sw_o[i] goes 0->1.
REQ-009 fall_o, output, WIDTH bits: one-cycle pulse per channel when sw_o[i] goes 1->0.
REQ-010 any_change_o, output, 1 bit: the OR of all rise_o and fall_o bits in the same cycle.

Function
REQ-011 Each channel SHALL pass sw_raw[i] through a two-flop synchronizer (sync1, then sync2) before any other logic uses it.
REQ-012 Each channel SHALL hold a CNT_W-bit counter cnt[i] and a stable level sw_o[i].
REQ-013 If sync2[i] equals sw_o[i], cnt[i] SHALL clear to 0 on the next edge.
REQ-014 If sync2[i] differs from sw_o[i] and cnt[i] is below DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-015 If sync2[i] differs from sw_o[i] and cnt[i] equals DEBOUNCE_CYCLES-1, the following SHALL happen on that edge:
- sw_o[i] loads sync2[i];
- cnt[i] clears to 0;
- rise_o[i] or fall_o[i] (per the new level) is registered high for exactly one cycle.
REQ-016 Latency SHALL be fixed for a clean input step: count the edge that first captures the new value into sync1 as edge 1; sw_o[i] and its pulse change at edge DEBOUNCE_CYCLES+2.
REQ-017 Any return of sync2[i] to sw_o[i] before the threshold SHALL discard the partial count; no glitch shorter than DEBOUNCE_CYCLES cycles may reach sw_o.
REQ-018 The counter SHALL never wrap: it is bounded by REQ-014 and REQ-015.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL update in the same cycle with their own pulses.
REQ-020 rise_o, fall_o and any_change_o SHALL be registered outputs, low in every cycle without a qualifying update.
REQ-021 With DEBOUNCE_CYCLES=1, an update SHALL occur at edge 3, on the first mismatch cycle.

Reset
REQ-022 While rstn is low at a rising edge, the following SHALL clear to 0 regardless of sw_raw:
- sync1 and sync2;
- all cnt[i] and all sw_o bits;
- rise_o, fall_o and any_change_o.
REQ-023 A reset asserted mid-count SHALL abort the count; after release, a held input needs the full DEBOUNCE_CYCLES+2 edges again.
REQ-024 If sw_raw bits are high at reset release, they SHALL be treated as a normal 0->1 transition: rise_o pulses after DEBOUNCE_CYCLES+2 edges.

Verification (DEBOUNCE_CYCLES=4, WIDTH=16)
REQ-025 Reset: sw_raw=16'hFFFF, rstn low 3 edges -> sw_o=0, rise_o=0, fall_o=0, any_change_o=0 throughout the reset; then sw_o=16'hFFFF at edge 6 after release, with rise_o=16'hFFFF for one cycle.
REQ-026 Clean step: sw_raw[0] 0->1 held -> sw_o[0]=1 at edge 6; rise_o[0]=1 and any_change_o=1 only in that cycle; other bits unchanged.
REQ-027 Glitch: sw_raw[3]=1 for 3 cycles, then 0 -> sw_o[3] stays 0; rise_o[3], fall_o[3] and any_change_o never assert.
REQ-028 Simultaneous: sw_o[2]=1 settled, then sw_raw[1] 0->1 and sw_raw[2] 1->0 in the same cycle -> at edge 6, sw_o[2:1]=2'b01, rise_o=16'h0002, fall_o=16'h0004.
REQ-029 Reset mid-count: sw_raw[5] 0->1, rstn low at edge 4 for one edge -> sw_o[5]=0; after release, sw_o[5]=1 exactly 6 edges later.
REQ-030 Bounce train: sw_raw[7] toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one rise_o[7] pulse, 6 edges after the final hold begins.

Source files
------------

// File: rtl/sw_debounce_if.sv
// Switch debouncer bus: groups the raw switch pins and the debounced
// level / edge-pulse outputs into one bundle.
//   sw_raw       : asynchronous, bouncing switch pins (into the debouncer)
//   sw_o         : debounced switch levels
//   rise_o       : one-cycle pulse per channel on a debounced 0->1
//   fall_o       : one-cycle pulse per channel on a debounced 1->0
//   any_change_o : OR of all rise_o / fall_o bits in the same cycle
// master: the side that owns the pins and consumes the results.
// slave : the debouncer itself.
interface sw_debounce_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             any_change_o;

  modport master (
    output sw_raw,
    input  sw_o,
    input  rise_o,
    input  fall_o,
    input  any_change_o
  );

  modport slave (
    input  sw_raw,
    output sw_o,
    output rise_o,
    output fall_o,
    output any_change_o
  );
endinterface

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer.
// Each channel synchronizes its raw pin through two flops, then requires the
// synchronized value to differ from the current debounced level for
// DEBOUNCE_CYCLES consecutive clocks before the debounced level follows it.
// A clean step therefore appears on sw_o DEBOUNCE_CYCLES+2 edges after the
// first synchronizer flop captures it; any shorter excursion is discarded.
// Ports:
//   clk  : board clock, all state on its rising edge
//   rstn : synchronous active-low reset, clears every register
//   bus  : sw_debounce_if slave (sw_raw in; sw_o, rise_o, fall_o,
//          any_change_o out, all outputs registered)
module sw_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic         clk,
  input  logic         rstn,
  sw_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_p0;
  logic [WIDTH-1:0] sync2_p1;
  logic [WIDTH-1:0] sw_p2;
  logic [WIDTH-1:0] rise_p2;
  logic [WIDTH-1:0] fall_p2;
  logic             any_p2;
  logic [WIDTH-1:0] upd;
  logic [CNT_W-1:0] cnt [WIDTH];

  // A channel flips on the edge where it is still mismatched and its count
  // has already reached the threshold; this also covers DEBOUNCE_CYCLES=1,
  // where the very first mismatch cycle updates.
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (sync2_p1[i] != sw_p2[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_p0 <= '0;
      sync2_p1 <= '0;
      sw_p2    <= '0;
      rise_p2  <= '0;
      fall_p2  <= '0;
      any_p2   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // stage p0 -> p1: two-flop synchronizer
      sync1_p0 <= bus.sw_raw;
      sync2_p1 <= sync1_p0;
      // stage p1 -> p2: per-channel stability counter and debounced level
      for (int i = 0; i < WIDTH; i++) begin
        // A match discards any partial count; an update restarts it.
        if ((sync2_p1[i] == sw_p2[i]) || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      sw_p2   <= sw_p2 ^ upd;
      rise_p2 <= upd & sync2_p1;
      fall_p2 <= upd & ~sync2_p1;
      any_p2  <= |upd;
    end
  end

  assign bus.sw_o         = sw_p2;
  assign bus.rise_o       = rise_p2;
  assign bus.fall_o       = fall_p2;
  assign bus.any_change_o = any_p2;

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce (WIDTH=16, DEBOUNCE_CYCLES=4).
// A behavioural model predicts every output from a sliding window of the
// synchronized input history; a negedge process compares it each cycle.
// Directed sequences pin reset, clean step, glitch, simultaneous change,
// reset mid-count and a bounce train to literal values, then a randomized
// phase exercises the model comparison.
module tb_sw_debounce;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] raw = 16'hFFFF;

  int tests = 0;
  int fails = 0;

  sw_debounce_if #(.WIDTH(W)) bus ();
  assign bus.sw_raw = raw;

  sw_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model state (value after the most recent rising edge).
  bit [W-1:0] m_s1, m_s2, m_sw, m_rise, m_fall;
  bit         m_any;
  bit [W-1:0] seen[$];   // synchronized values observed at edges since reset
  bit         m_valid = 1'b0;

  // A channel changes when the last D synchronized samples all differ from
  // its current debounced level.
  task automatic model_edge(input bit [W-1:0] r, input bit rn);
    bit [W-1:0] used, upd;
    bit         all;
    if (!rn) begin
      m_s1 = '0; m_s2 = '0; m_sw = '0;
      m_rise = '0; m_fall = '0; m_any = 1'b0;
      seen.delete();
    end else begin
      used = m_s2;
      seen.push_back(used);
      if (seen.size() > D) void'(seen.pop_front());
      upd = '0;
      if (seen.size() == D) begin
        for (int i = 0; i < W; i++) begin
          all = 1'b1;
          foreach (seen[j]) if (seen[j][i] == m_sw[i]) all = 1'b0;
          upd[i] = all;
        end
      end
      m_rise = upd & used;
      m_fall = upd & ~used;
      m_any  = (upd != 0);
      m_sw   = m_sw ^ upd;
      m_s2   = m_s1;
      m_s1   = r;
    end
  endtask

  // Inputs change 2 time units after a rising edge, so at the falling edge
  // they hold what the next rising edge will capture.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_sw_o", 32'(bus.sw_o), 32'(m_sw));
      check("model_rise_o", 32'(bus.rise_o), 32'(m_rise));
      check("model_fall_o", 32'(bus.fall_o), 32'(m_fall));
      check("model_any_change_o", 32'(bus.any_change_o), 32'(m_any));
    end
    model_edge(raw, rstn);
    m_valid = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held with all pins high.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_sw_o", 32'(bus.sw_o), 32'h0);
      check("rst_rise_o", 32'(bus.rise_o), 32'h0);
      check("rst_fall_o", 32'(bus.fall_o), 32'h0);
      check("rst_any", 32'(bus.any_change_o), 32'h0);
    end
    rstn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 6) check("rel_sw_early", 32'(bus.sw_o), 32'h0);
      if (k == 6) begin
        check("rel_sw_o", 32'(bus.sw_o), 32'hFFFF);
        check("rel_rise_o", 32'(bus.rise_o), 32'hFFFF);
        check("rel_model_sw", 32'(m_sw), 32'hFFFF);
      end
      if (k == 7) check("rel_rise_gone", 32'(bus.rise_o), 32'h0);
    end
    // Return to all-low.
    raw = 16'h0000;
    for (int k = 1; k <= 6; k++) tick();
    check("all_fall_o", 32'(bus.fall_o), 32'hFFFF);
    check("all_sw_low", 32'(bus.sw_o), 32'h0);

    // Clean step on channel 0.
    raw = 16'h0001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) check("step_sw_early", 32'(bus.sw_o), 32'h0);
      if (k == 6) begin
        check("step_sw_o", 32'(bus.sw_o), 32'h0001);
        check("step_rise_o", 32'(bus.rise_o), 32'h0001);
        check("step_any", 32'(bus.any_change_o), 32'h1);
        check("step_model_rise", 32'(m_rise), 32'h0001);
      end
      if (k == 7) check("step_any_gone", 32'(bus.any_change_o), 32'h0);
    end

    // Three-cycle glitch on channel 3 must be swallowed.
    raw = 16'h0009;
    for (int k = 0; k < 3; k++) tick();
    raw = 16'h0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("glitch_sw_o", 32'(bus.sw_o), 32'h0001);
      check("glitch_any", 32'(bus.any_change_o), 32'h0);
    end

    // Simultaneous rise on channel 1 and fall on channel 2.
    raw = 16'h0005;
    for (int k = 0; k < 8; k++) tick();
    check("simul_pre", 32'(bus.sw_o), 32'h0005);
    raw = 16'h0003;
    for (int k = 1; k <= 6; k++) tick();
    check("simul_sw_o", 32'(bus.sw_o), 32'h0003);
    check("simul_rise_o", 32'(bus.rise_o), 32'h0002);
    check("simul_fall_o", 32'(bus.fall_o), 32'h0004);

    // Reset mid-count on channel 5.
    raw = 16'h0023;
    for (int k = 0; k < 3; k++) tick();
    rstn = 1'b0;
    tick();
    check("midrst_sw_o", 32'(bus.sw_o), 32'h0);
    rstn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check("midrst_sw5_early", 32'(bus.sw_o[5]), 32'h0);
    end
    check("midrst_sw_o_after", 32'(bus.sw_o), 32'h0023);
    check("midrst_rise_o", 32'(bus.rise_o), 32'h0023);

    // Bounce train on channel 7, then a steady high.
    begin
      int pulses = 0;
      for (int c = 0; c < 20; c++) begin
        raw[7] = ((c / 2) % 2) == 0;
        tick();
        if (bus.rise_o[7]) pulses++;
      end
      raw[7] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (bus.rise_o[7]) pulses++;
        if (k == 6) check("bounce_rise7_at_6", 32'(bus.rise_o[7]), 32'h1);
      end
      check("bounce_pulse_count", 32'(pulses), 32'd1);
      check("bounce_sw7", 32'(bus.sw_o[7]), 32'h1);
    end

    // Randomized phase against the model.
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 299) != 0);
      raw  = raw ^ W'($urandom & $urandom & $urandom);
      tick();
    end
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
